// File: rtl/uart_line_editor.sv
// Line-editing terminal front end: echoes typed bytes with prompt, backspace and
// overflow handling, holds completed lines for random access, and splices in host messages.
module uart_line_editor #(
  parameter int          LINE_LEN       = 64,
  parameter logic [7:0]  PROMPT_CH      = "$",
  parameter int          STARTUP_CYCLES = 32768,
  parameter bit          ECHO           = 1'b1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              rx_valid,
  input  logic [7:0]                        rx_data,
  output logic                              rx_ready,
  output logic                              tx_valid,
  output logic [7:0]                        tx_data,
  input  logic                              tx_ready,
  output logic                              line_valid,
  output logic [$clog2(LINE_LEN+1)-1:0]     line_len,
  input  logic [$clog2(LINE_LEN)-1:0]       rd_addr,
  output logic [7:0]                        rd_data,
  input  logic                              line_ack,
  input  logic                              msg_valid,
  input  logic [7:0]                        msg_data,
  input  logic                              msg_last,
  output logic                              msg_ready
);
  localparam int CW = $clog2(LINE_LEN + 1);
  localparam int AW = $clog2(LINE_LEN);

  localparam logic [3:0] S_WAIT   = 4'd0;
  localparam logic [3:0] S_PROMPT = 4'd1;
  localparam logic [3:0] S_IDLE   = 4'd2;
  localparam logic [3:0] S_ECHO   = 4'd3;
  localparam logic [3:0] S_BS     = 4'd4;
  localparam logic [3:0] S_NL     = 4'd5;
  localparam logic [3:0] S_HOLD   = 4'd6;
  localparam logic [3:0] S_MSG    = 4'd7;
  localparam logic [3:0] S_MSGNL  = 4'd8;
  localparam logic [3:0] S_REDRAW = 4'd9;

  logic [3:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [31:0]   wait_q, wait_d;
  logic [7:0]    ch_q, ch_d;
  logic          cr_seen_q, cr_seen_d;
  logic          tx_valid_q, tx_valid_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          line_valid_q, line_valid_d;
  logic [CW-1:0] line_len_q, line_len_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic [7:0]    buf_mem [0:LINE_LEN-1];

  logic          tx_free;
  logic          load;
  logic [7:0]    load_byte;
  logic          buf_we;
  logic          printable;

  assign tx_free   = !tx_valid_q || tx_ready;
  assign printable = (rx_data >= 8'h20) && (rx_data <= 8'h7E);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    wait_d       = wait_q;
    ch_d         = ch_q;
    cr_seen_d    = cr_seen_q;
    line_valid_d = line_valid_q;
    line_len_d   = line_len_q;
    tx_valid_d   = tx_valid_q;
    tx_data_d    = tx_data_q;
    rx_ready     = 1'b0;
    msg_ready    = 1'b0;
    buf_we       = 1'b0;
    load         = 1'b0;
    load_byte    = 8'h00;
    rd_data_d    = (int'(rd_addr) < LINE_LEN) ? buf_mem[rd_addr] : 8'h00;
    if (tx_ready) tx_valid_d = 1'b0;

    case (state_q)
      S_WAIT: begin
        if (wait_q == 32'(STARTUP_CYCLES)) state_d = S_PROMPT;
        else wait_d = wait_q + 32'd1;
      end
      S_PROMPT: if (tx_free) begin
        load      = 1'b1;
        load_byte = (idx_q == '0) ? PROMPT_CH : 8'h20;
        if (idx_q == '0) idx_d = CW'(1);
        else begin
          idx_d   = '0;
          state_d = (cnt_q != '0) ? S_REDRAW : S_IDLE;
        end
      end
      S_IDLE: begin
        if (msg_valid) begin
          state_d = S_MSG;
          idx_d   = '0;
        end else if (rx_valid && !tx_valid_q) begin
          // Only pop when nothing is waiting in the tx register.
          rx_ready  = 1'b1;
          cr_seen_d = 1'b0;
          if (printable) begin
            if (cnt_q < CW'(LINE_LEN)) begin
              buf_we = 1'b1;
              cnt_d  = cnt_q + 1'b1;
              ch_d   = rx_data;
              if (ECHO) state_d = S_ECHO;
            end else begin
              load      = 1'b1;
              load_byte = 8'h07;
            end
          end else if (rx_data == 8'h08 || rx_data == 8'h7F) begin
            if (cnt_q != '0) begin
              cnt_d   = cnt_q - 1'b1;
              idx_d   = '0;
              state_d = S_BS;
            end
          end else if (rx_data == 8'h0D) begin
            cr_seen_d = 1'b1;
            idx_d     = '0;
            state_d   = S_NL;
          end else if (rx_data == 8'h0A && !cr_seen_q) begin
            idx_d   = '0;
            state_d = S_NL;
          end
        end
      end
      S_ECHO: if (tx_free) begin
        load      = 1'b1;
        load_byte = ch_q;
        state_d   = S_IDLE;
      end
      S_BS: if (tx_free) begin
        load      = 1'b1;
        load_byte = (idx_q == CW'(1)) ? 8'h20 : 8'h08;
        if (idx_q == CW'(2)) begin
          idx_d   = '0;
          state_d = S_IDLE;
        end else idx_d = idx_q + 1'b1;
      end
      S_NL, S_MSGNL: if (tx_free) begin
        load      = 1'b1;
        load_byte = (idx_q == '0) ? 8'h0D : 8'h0A;
        if (idx_q == '0) idx_d = CW'(1);
        else begin
          idx_d = '0;
          if (state_q == S_NL && cnt_q != '0) begin
            line_len_d   = cnt_q;
            line_valid_d = 1'b1;
            state_d      = S_HOLD;
          end else state_d = S_PROMPT;
        end
      end
      S_HOLD: if (line_ack) begin
        line_valid_d = 1'b0;
        cnt_d        = '0;
        state_d      = S_PROMPT;
      end
      S_MSG: begin
        if (idx_q < CW'(2)) begin
          if (tx_free) begin
            load      = 1'b1;
            load_byte = (idx_q == '0) ? 8'h0D : 8'h0A;
            idx_d     = idx_q + 1'b1;
          end
        end else begin
          // Message bytes pass straight through, throttled by the tx side.
          msg_ready = tx_ready;
          if (msg_valid && tx_ready) begin
            load      = 1'b1;
            load_byte = msg_data;
            if (msg_last) begin
              idx_d   = '0;
              state_d = S_MSGNL;
            end
          end
        end
      end
      S_REDRAW: begin
        if (idx_q < cnt_q) begin
          if (tx_free) begin
            load      = 1'b1;
            load_byte = buf_mem[idx_q[AW-1:0]];
            idx_d     = idx_q + 1'b1;
          end
        end else begin
          idx_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_WAIT;
    endcase

    if (load) begin
      tx_valid_d = 1'b1;
      tx_data_d  = load_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) buf_mem[cnt_q[AW-1:0]] <= rx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_WAIT;
      cnt_q        <= '0;
      idx_q        <= '0;
      wait_q       <= '0;
      ch_q         <= '0;
      cr_seen_q    <= 1'b0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
      line_valid_q <= 1'b0;
      line_len_q   <= '0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      wait_q       <= wait_d;
      ch_q         <= ch_d;
      cr_seen_q    <= cr_seen_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      line_valid_q <= line_valid_d;
      line_len_q   <= line_len_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign tx_valid   = tx_valid_q;
  assign tx_data    = tx_data_q;
  assign line_valid = line_valid_q;
  assign line_len   = line_len_q;
  assign rd_data    = rd_data_q;
endmodule
